pe_array_sequencer: RTL and testbench
=====================================

// Module: pe_array_sequencer
// PURPOSE
//  Sequences one matrix-vector layer pass on the PE array: accepts a command, streams N input-channel tiles
//  (act + weight memory reads), aligns PE control strobes to memory read latency, and flags result-valid once
//  the column accumulators hold the final sum. Sits between the layer controller and pe_array + its SRAMs.
// PARAMETERS
//  TILE_CNT_W    8   width of tile count (max 2**TILE_CNT_W-1 tiles per pass)
//  ACT_ADDR_W    10  activation memory address width
//  W_ADDR_W      12  weight memory address width
//  SCALE_BIT_WIDTH 4 width of in/out scale shifts
//  MEM_LATENCY   1   cycles from rd_en to data at pe_array inputs (>=1)
// PORTS
//  clk                  in  1            clock
//  rst                  in  1            async active-high reset
//  cmd_valid/cmd_ready  in/out 1         command handshake; transfer when both high
//  cmd_num_tiles        in  TILE_CNT_W   tiles to accumulate; 0 treated as 1
//  cmd_act_base         in  ACT_ADDR_W   first activation address
//  cmd_w_base           in  W_ADDR_W     first weight address
//  cmd_use_subsection, cmd_apply_identity, cmd_apply_in_scale  in 1   mode flags
//  cmd_in_scale, cmd_out_scale  in SCALE_BIT_WIDTH  shifts
//  act_rd_en/act_rd_addr out 1/ACT_ADDR_W activation read
//  w_rd_en/w_rd_addr    out 1/W_ADDR_W   weight read
//  pe_enable, pe_apply_bias, pe_apply_identity, pe_apply_in_scale, pe_use_subsection  out 1  to pe_array
//  pe_in_scale, pe_out_scale  out SCALE_BIT_WIDTH  to pe_array
//  res_valid/res_ready  out/in 1         result handshake (pe_array out/col_accumulator stable while valid)
// BEHAVIOUR
//  - Reset: state IDLE; cmd_ready=1; all rd_en, pe_* strobes, res_valid =0; addresses, scales, counters =0.
//  - Command fields registered on accept; pe_* mode/scale outputs driven from the register, stable until next accept.
//  - FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
//    IDLE: cmd_ready=1; on accept -> ISSUE, tile_cnt=0, addrs=bases.
//    ISSUE: act_rd_en=1 each cycle, addr+1 per tile; w_rd_en=1 unless identity; after last tile issued -> DRAIN.
//    DRAIN: wait for delay line empty (MEM_LATENCY cycles) -> DONE.
//    DONE: res_valid=1, held until res_ready; then -> IDLE. res_valid high 1 cycle after last pe_enable.
//  - Identity mode: tile count forced to 1, w_rd_en stays 0.
//  - Delay line of depth MEM_LATENCY carries {valid, first}: pe_enable = delayed valid, pe_apply_bias = delayed first.
//    Exactly one pe_apply_bias per pass, coincident with tile 0 data; no bubbles between tiles.
//  - Pass of N tiles: cmd accept at cycle 0 -> rd_en cycles 1..N -> pe_enable cycles 1+L..N+L -> res_valid N+L+1.
//  - Address counters wrap modulo 2**width without error.
//  - cmd_ready=0 outside IDLE; cmd_valid ignored. res_ready outside DONE ignored.
//  - Reset mid-pass: immediate abort, delay line cleared, no res_valid; next pass restarts with bias.
// CONFIGURATION
//  SEQ_PERF_COUNTERS_EN: defined -> adds outputs perf_busy_cycles[31:0] (cycles not in IDLE) and
//  perf_passes[15:0] (completed res handshakes), both saturating, cleared by rst. Undefined -> ports and logic absent,
//  behaviour otherwise identical.
// STRUCTURE
//  Package pe_seq_pkg: seq_state_e enum (IDLE, ISSUE, DRAIN, DONE), seq_cmd_t struct of cmd fields,
//  localparam for MEM_LATENCY default. Sub-module seq_delay_line (param DEPTH, WIDTH; shift register, async clear).
// TESTING
//  1. MEM_LATENCY=1, num_tiles=4, act_base=10, w_base=100 -> act_rd_addr 10..13, w_rd_addr 100..103 consecutive cycles,
//     pe_enable 4 cycles, pe_apply_bias only first, res_valid at cycle 6.
//  2. num_tiles=0 -> behaves as 1 tile; identity=1, num_tiles=5 -> one act read, w_rd_en never high.
//  3. MEM_LATENCY=3, num_tiles=2 -> pe_enable cycles 4..5, res_valid cycle 6; res_ready low 5 cycles -> valid held, cmd_ready=0.
//  4. act_base=1022 (ACT_ADDR_W=10), num_tiles=4 -> addresses 1022,1023,0,1.
//  5. rst pulse during ISSUE tile 2 of 8 -> all outputs 0 next edge; new cmd re-issues from base with bias first.
//  6. SEQ_PERF_COUNTERS_EN, two 3-tile passes at MEM_LATENCY=1 -> perf_passes=2, perf_busy_cycles=10.

Source files
------------

// File: rtl/pe_seq_pkg.sv
// Shared types for the PE array sequencer: FSM state, registered command flags,
// default memory read latency and a counter-width helper.
package pe_seq_pkg;

  localparam int unsigned MEM_LATENCY_DEF = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic use_subsection;
    logic apply_identity;
    logic apply_in_scale;
  } seq_cmd_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_delay_line.sv
// Fixed-depth shift register with async clear; aligns issue-side strobes with
// memory read data arriving DEPTH cycles later.
module seq_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_comb stage_d[gi] = din;
      end else begin : g_tail
        always_comb stage_d[gi] = stage_q[gi-1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) stage_q[gi] <= '0;
        else     stage_q[gi] <= stage_d[gi];
      end
    end
  endgenerate

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/pe_array_sequencer.sv
// Sequences one matrix-vector layer pass: issues N tile reads, aligns PE strobes to
// memory latency and raises res_valid when accumulators are final. SEQ_PERF_COUNTERS_EN adds perf counters.
module pe_array_sequencer
  import pe_seq_pkg::*;
#(
  parameter int unsigned TILE_CNT_W      = 8,
  parameter int unsigned ACT_ADDR_W      = 10,
  parameter int unsigned W_ADDR_W        = 12,
  parameter int unsigned SCALE_BIT_WIDTH = 4,
  parameter int unsigned MEM_LATENCY     = MEM_LATENCY_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [TILE_CNT_W-1:0]      cmd_num_tiles,
  input  logic [ACT_ADDR_W-1:0]      cmd_act_base,
  input  logic [W_ADDR_W-1:0]        cmd_w_base,
  input  logic                       cmd_use_subsection,
  input  logic                       cmd_apply_identity,
  input  logic                       cmd_apply_in_scale,
  input  logic [SCALE_BIT_WIDTH-1:0] cmd_in_scale,
  input  logic [SCALE_BIT_WIDTH-1:0] cmd_out_scale,
  output logic                       act_rd_en,
  output logic [ACT_ADDR_W-1:0]      act_rd_addr,
  output logic                       w_rd_en,
  output logic [W_ADDR_W-1:0]        w_rd_addr,
  output logic                       pe_enable,
  output logic                       pe_apply_bias,
  output logic                       pe_apply_identity,
  output logic                       pe_apply_in_scale,
  output logic                       pe_use_subsection,
  output logic [SCALE_BIT_WIDTH-1:0] pe_in_scale,
  output logic [SCALE_BIT_WIDTH-1:0] pe_out_scale,
  output logic                       res_valid,
  input  logic                       res_ready
`ifdef SEQ_PERF_COUNTERS_EN
  ,
  output logic [31:0]                perf_busy_cycles,
  output logic [15:0]                perf_passes
`endif
);

  localparam int unsigned DRAIN_W = cnt_width(MEM_LATENCY);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MEM_LATENCY - 1);

  seq_state_e                 state_q, state_d;
  seq_cmd_t                   cmd_q, cmd_d;
  logic [TILE_CNT_W-1:0]      last_tile_q, last_tile_d;
  logic [TILE_CNT_W-1:0]      tile_cnt_q, tile_cnt_d;
  logic [ACT_ADDR_W-1:0]      act_addr_q, act_addr_d;
  logic [W_ADDR_W-1:0]        w_addr_q, w_addr_d;
  logic [SCALE_BIT_WIDTH-1:0] in_scale_q, in_scale_d;
  logic [SCALE_BIT_WIDTH-1:0] out_scale_q, out_scale_d;
  logic [DRAIN_W-1:0]         drain_cnt_q, drain_cnt_d;
  logic                       issue_first;
  logic [1:0]                 dl_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      last_tile_q <= '0;
      tile_cnt_q  <= '0;
      act_addr_q  <= '0;
      w_addr_q    <= '0;
      in_scale_q  <= '0;
      out_scale_q <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      last_tile_q <= last_tile_d;
      tile_cnt_q  <= tile_cnt_d;
      act_addr_q  <= act_addr_d;
      w_addr_q    <= w_addr_d;
      in_scale_q  <= in_scale_d;
      out_scale_q <= out_scale_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = ISSUE;
      ISSUE:   if (tile_cnt_q == last_tile_q) state_d = DRAIN;
      DRAIN:   if (drain_cnt_q == DRAIN_LAST) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers; address counters wrap naturally at their width.
  always_comb begin
    cmd_d       = cmd_q;
    last_tile_d = last_tile_q;
    tile_cnt_d  = tile_cnt_q;
    act_addr_d  = act_addr_q;
    w_addr_d    = w_addr_q;
    in_scale_d  = in_scale_q;
    out_scale_d = out_scale_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_d.use_subsection = cmd_use_subsection;
          cmd_d.apply_identity = cmd_apply_identity;
          cmd_d.apply_in_scale = cmd_apply_in_scale;
          last_tile_d = (cmd_apply_identity || cmd_num_tiles == '0) ? '0 : cmd_num_tiles - 1'b1;
          tile_cnt_d  = '0;
          act_addr_d  = cmd_act_base;
          w_addr_d    = cmd_w_base;
          in_scale_d  = cmd_in_scale;
          out_scale_d = cmd_out_scale;
        end
      end
      ISSUE: begin
        tile_cnt_d  = tile_cnt_q + 1'b1;
        act_addr_d  = act_addr_q + 1'b1;
        w_addr_d    = w_addr_q + 1'b1;
        drain_cnt_d = '0;
      end
      DRAIN:   drain_cnt_d = drain_cnt_q + 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cmd_ready   = (state_q == IDLE);
    act_rd_en   = (state_q == ISSUE);
    w_rd_en     = (state_q == ISSUE) && !cmd_q.apply_identity;
    res_valid   = (state_q == DONE);
    issue_first = (state_q == ISSUE) && (tile_cnt_q == '0);
  end

  seq_delay_line #(
    .DEPTH (MEM_LATENCY),
    .WIDTH (2)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({act_rd_en, issue_first}),
    .dout (dl_out)
  );

  assign pe_enable         = dl_out[1];
  assign pe_apply_bias     = dl_out[0];
  assign act_rd_addr       = act_addr_q;
  assign w_rd_addr         = w_addr_q;
  assign pe_apply_identity = cmd_q.apply_identity;
  assign pe_apply_in_scale = cmd_q.apply_in_scale;
  assign pe_use_subsection = cmd_q.use_subsection;
  assign pe_in_scale       = in_scale_q;
  assign pe_out_scale      = out_scale_q;

`ifdef SEQ_PERF_COUNTERS_EN
  logic [31:0] busy_q, busy_d;
  logic [15:0] passes_q, passes_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= '0;
      passes_q <= '0;
    end else begin
      busy_q   <= busy_d;
      passes_q <= passes_d;
    end
  end

  always_comb begin
    busy_d   = busy_q;
    passes_d = passes_q;
    if (state_q != IDLE && busy_q != '1) busy_d = busy_q + 1'b1;
    if (state_q == DONE && res_ready && passes_q != '1) passes_d = passes_q + 1'b1;
  end

  assign perf_busy_cycles = busy_q;
  assign perf_passes      = passes_q;
`endif

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Directed bench for pe_array_sequencer: one instance at MEM_LATENCY=1, one at 3,
// per-cycle expected strobes derived from the pass timing (accept c0, rd c1..N, pe c1+L..N+L, res N+L+1).
module tb_pe_array_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid1, cmd_valid3, res_ready1, res_ready3;
  logic [7:0]  cmd_num_tiles;
  logic [9:0]  cmd_act_base;
  logic [11:0] cmd_w_base;
  logic        cmd_use_subsection, cmd_apply_identity, cmd_apply_in_scale;
  logic [3:0]  cmd_in_scale, cmd_out_scale;

  logic        cmd_ready1, act_rd_en1, w_rd_en1, pe_enable1, pe_apply_bias1, res_valid1;
  logic        pe_apply_identity1, pe_apply_in_scale1, pe_use_subsection1;
  logic [9:0]  act_rd_addr1;
  logic [11:0] w_rd_addr1;
  logic [3:0]  pe_in_scale1, pe_out_scale1;
  logic        cmd_ready3, act_rd_en3, w_rd_en3, pe_enable3, pe_apply_bias3, res_valid3;
  logic        pe_apply_identity3, pe_apply_in_scale3, pe_use_subsection3;
  logic [9:0]  act_rd_addr3;
  logic [11:0] w_rd_addr3;
  logic [3:0]  pe_in_scale3, pe_out_scale3;
`ifdef SEQ_PERF_COUNTERS_EN
  logic [31:0] perf_busy1, perf_busy3;
  logic [15:0] perf_passes1, perf_passes3;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic sel = 1'b0;

  always #5 clk = ~clk;

  pe_array_sequencer #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_num_tiles(cmd_num_tiles), .cmd_act_base(cmd_act_base), .cmd_w_base(cmd_w_base),
    .cmd_use_subsection(cmd_use_subsection), .cmd_apply_identity(cmd_apply_identity),
    .cmd_apply_in_scale(cmd_apply_in_scale), .cmd_in_scale(cmd_in_scale), .cmd_out_scale(cmd_out_scale),
    .act_rd_en(act_rd_en1), .act_rd_addr(act_rd_addr1), .w_rd_en(w_rd_en1), .w_rd_addr(w_rd_addr1),
    .pe_enable(pe_enable1), .pe_apply_bias(pe_apply_bias1), .pe_apply_identity(pe_apply_identity1),
    .pe_apply_in_scale(pe_apply_in_scale1), .pe_use_subsection(pe_use_subsection1),
    .pe_in_scale(pe_in_scale1), .pe_out_scale(pe_out_scale1),
    .res_valid(res_valid1), .res_ready(res_ready1)
`ifdef SEQ_PERF_COUNTERS_EN
    , .perf_busy_cycles(perf_busy1), .perf_passes(perf_passes1)
`endif
  );

  pe_array_sequencer #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_num_tiles(cmd_num_tiles), .cmd_act_base(cmd_act_base), .cmd_w_base(cmd_w_base),
    .cmd_use_subsection(cmd_use_subsection), .cmd_apply_identity(cmd_apply_identity),
    .cmd_apply_in_scale(cmd_apply_in_scale), .cmd_in_scale(cmd_in_scale), .cmd_out_scale(cmd_out_scale),
    .act_rd_en(act_rd_en3), .act_rd_addr(act_rd_addr3), .w_rd_en(w_rd_en3), .w_rd_addr(w_rd_addr3),
    .pe_enable(pe_enable3), .pe_apply_bias(pe_apply_bias3), .pe_apply_identity(pe_apply_identity3),
    .pe_apply_in_scale(pe_apply_in_scale3), .pe_use_subsection(pe_use_subsection3),
    .pe_in_scale(pe_in_scale3), .pe_out_scale(pe_out_scale3),
    .res_valid(res_valid3), .res_ready(res_ready3)
`ifdef SEQ_PERF_COUNTERS_EN
    , .perf_busy_cycles(perf_busy3), .perf_passes(perf_passes3)
`endif
  );

  // Observed signals of whichever instance the current step targets
  logic        o_cmd_ready, o_act_rd_en, o_w_rd_en, o_pe_enable, o_pe_bias, o_res_valid;
  logic        o_ident, o_subsec, o_in_sc_en;
  logic [9:0]  o_act_addr;
  logic [11:0] o_w_addr;
  logic [3:0]  o_in_scale, o_out_scale;
  assign o_cmd_ready = sel ? cmd_ready3         : cmd_ready1;
  assign o_act_rd_en = sel ? act_rd_en3         : act_rd_en1;
  assign o_w_rd_en   = sel ? w_rd_en3           : w_rd_en1;
  assign o_pe_enable = sel ? pe_enable3         : pe_enable1;
  assign o_pe_bias   = sel ? pe_apply_bias3     : pe_apply_bias1;
  assign o_res_valid = sel ? res_valid3         : res_valid1;
  assign o_ident     = sel ? pe_apply_identity3 : pe_apply_identity1;
  assign o_subsec    = sel ? pe_use_subsection3 : pe_use_subsection1;
  assign o_in_sc_en  = sel ? pe_apply_in_scale3 : pe_apply_in_scale1;
  assign o_act_addr  = sel ? act_rd_addr3       : act_rd_addr1;
  assign o_w_addr    = sel ? w_rd_addr3         : w_rd_addr1;
  assign o_in_scale  = sel ? pe_in_scale3       : pe_in_scale1;
  assign o_out_scale = sel ? pe_out_scale3      : pe_out_scale1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cmd_ready"}, 32'(o_cmd_ready), 1);
    check({tag, "_act_rd_en"}, 32'(o_act_rd_en), 0);
    check({tag, "_w_rd_en"},   32'(o_w_rd_en), 0);
    check({tag, "_pe_enable"}, 32'(o_pe_enable), 0);
    check({tag, "_pe_bias"},   32'(o_pe_bias), 0);
    check({tag, "_res_valid"}, 32'(o_res_valid), 0);
  endtask

  // One full pass; hold = cycles res_ready stays low once res_valid rises.
  task automatic run_pass(input bit use3, input int n, input int ab, input int wb,
                          input bit ident, input int hold);
    int lat, eff, dlast;
    lat   = use3 ? 3 : 1;
    eff   = (ident || n == 0) ? 1 : n;
    dlast = eff + lat + 1;
    @(negedge clk);
    sel = use3;
    #1;
    check("pre_cmd_ready", 32'(o_cmd_ready), 1);
    cmd_num_tiles      = 8'(n);
    cmd_act_base       = 10'(ab);
    cmd_w_base         = 12'(wb);
    cmd_apply_identity = ident;
    cmd_use_subsection = ab[0];
    cmd_apply_in_scale = wb[0];
    cmd_in_scale       = 4'(ab);
    cmd_out_scale      = 4'(wb);
    if (use3) begin cmd_valid3 = 1'b1; res_ready3 = (hold == 0); end
    else      begin cmd_valid1 = 1'b1; res_ready1 = (hold == 0); end
    @(negedge clk);
    cmd_valid1 = 1'b0;
    cmd_valid3 = 1'b0;
    cmd_num_tiles = 8'd0;
    cmd_act_base  = 10'd0;
    cmd_w_base    = 12'd0;
    cmd_apply_identity = 1'b0;
    cmd_in_scale  = 4'd0;
    for (int c = 1; c <= dlast + hold; c++) begin
      check("act_rd_en", 32'(o_act_rd_en), 32'(c <= eff));
      check("w_rd_en", 32'(o_w_rd_en), 32'(c <= eff && !ident));
      if (c <= eff) begin
        check("act_rd_addr", 32'(o_act_addr), 32'((ab + c - 1) % 1024));
        if (!ident) check("w_rd_addr", 32'(o_w_addr), 32'((wb + c - 1) % 4096));
      end
      check("pe_enable", 32'(o_pe_enable), 32'(c >= 1 + lat && c <= eff + lat));
      check("pe_apply_bias", 32'(o_pe_bias), 32'(c == 1 + lat));
      check("res_valid", 32'(o_res_valid), 32'(c >= dlast));
      check("busy_cmd_ready", 32'(o_cmd_ready), 0);
      if (c == 1) begin
        check("pe_apply_identity", 32'(o_ident), 32'(ident));
        check("pe_use_subsection", 32'(o_subsec), 32'(ab % 2));
        check("pe_apply_in_scale", 32'(o_in_sc_en), 32'(wb % 2));
        check("pe_in_scale", 32'(o_in_scale), 32'(ab % 16));
        check("pe_out_scale", 32'(o_out_scale), 32'(wb % 16));
      end
      if (c == dlast + hold) begin
        if (use3) begin cmd_valid3 = 1'b0; res_ready3 = 1'b1; end
        else      begin cmd_valid1 = 1'b0; res_ready1 = 1'b1; end
      end else if (c >= dlast) begin
        if (use3) cmd_valid3 = 1'b1; else cmd_valid1 = 1'b1;
      end
      @(negedge clk);
    end
    check_idle("post");
    check("post_scale_held", 32'(o_out_scale), 32'(wb % 16));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cmd_valid1 = 1'b0; cmd_valid3 = 1'b0; res_ready1 = 1'b0; res_ready3 = 1'b0;
    cmd_num_tiles = '0; cmd_act_base = '0; cmd_w_base = '0;
    cmd_use_subsection = 1'b0; cmd_apply_identity = 1'b0; cmd_apply_in_scale = 1'b0;
    cmd_in_scale = '0; cmd_out_scale = '0;
    repeat (2) @(negedge clk);
    sel = 1'b0; #1;
    check_idle("rst1");
    check("rst1_act_addr", 32'(o_act_addr), 0);
    check("rst1_w_addr", 32'(o_w_addr), 0);
    sel = 1'b1; #1;
    check_idle("rst3");
    check("rst3_out_scale", 32'(o_out_scale), 0);
    @(negedge clk);
    rst = 1'b0;

    run_pass(1'b0, 4, 10, 100, 1'b0, 0);     // basic 4-tile pass, L=1
    run_pass(1'b0, 0, 20, 200, 1'b0, 0);     // zero tiles behaves as one
    run_pass(1'b0, 5, 30, 301, 1'b1, 0);     // identity: one act read, no weights
    run_pass(1'b1, 2, 51, 500, 1'b0, 5);     // L=3 with result back-pressure
    run_pass(1'b0, 4, 1022, 4094, 1'b0, 0);  // address wrap on both memories

    // Reset while tile 2 of 8 is being issued
    @(negedge clk);
    sel = 1'b0;
    cmd_num_tiles = 8'd8; cmd_act_base = 10'd40; cmd_w_base = 12'd400;
    cmd_apply_identity = 1'b0; cmd_out_scale = 4'd9;
    cmd_valid1 = 1'b1; res_ready1 = 1'b1;
    @(negedge clk);
    cmd_valid1 = 1'b0;
    check("abort_c1_addr", 32'(o_act_addr), 40);
    @(negedge clk);
    @(negedge clk);
    check("abort_c3_addr", 32'(o_act_addr), 42);
    check("abort_c3_bias", 32'(o_pe_bias), 0);
    check("abort_c3_enable", 32'(o_pe_enable), 1);
    rst = 1'b1;
    #1;
    check_idle("abort");
    check("abort_act_addr", 32'(o_act_addr), 0);
    check("abort_out_scale", 32'(o_out_scale), 0);
    @(negedge clk);
    rst = 1'b0;
    run_pass(1'b0, 8, 40, 400, 1'b0, 0);

`ifdef SEQ_PERF_COUNTERS_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("perf_busy_cleared", perf_busy1, 0);
    run_pass(1'b0, 3, 60, 600, 1'b0, 0);
    run_pass(1'b0, 3, 70, 700, 1'b0, 0);
    check("perf_passes", 32'(perf_passes1), 2);
    check("perf_busy_cycles", perf_busy1, 10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
